// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, default widths,
// and the halt sentinel word.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int ADX_LENGTH_DEF  = 7;
    localparam int BOOT_CYCLES_DEF = 16;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction SRAM read bus; the fetch unit is master, the SRAM is slave.
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADX_LENGTH = 7
);
    logic [ADX_LENGTH-1:0] im_adx;
    logic                  im_wren;
    logic [DATA_WIDTH-1:0] im_data;

    modport master (output im_adx, output im_wren, input  im_data);
    modport slave  (input  im_adx, input  im_wren, output im_data);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: load beats hold, hold beats increment; wraps
// modulo 2^ADX_LENGTH.
module fetch_pc_reg #(
    parameter int ADX_LENGTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [ADX_LENGTH-1:0] load_val_i,
    input  logic                  inc_i,
    input  logic                  hold_i,
    output logic [ADX_LENGTH-1:0] pc_o
);

    logic [ADX_LENGTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = load_val_i;
        else if (!hold_i && inc_i)
            pc_d = pc_q + ADX_LENGTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: boot wait, PC sequencing with branch/stall, and the
// IF/ID register that tags each fetched word with its address.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int                    ADX_LENGTH  = ADX_LENGTH_DEF,
    parameter int                    BOOT_CYCLES = BOOT_CYCLES_DEF,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD   = DATA_WIDTH'(HALT_WORD_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     im,
    input  logic                   stall,
    input  logic                   branch_en,
    input  logic [ADX_LENGTH-1:0]  branch_target,
    output logic [ADX_LENGTH-1:0]  pc,
    output logic [DATA_WIDTH-1:0]  instr,
    output logic [ADX_LENGTH-1:0]  instr_pc,
    output logic                   instr_valid,
    output logic                   halted
);

    localparam int BW = $clog2(BOOT_CYCLES + 1);

    fetch_state_e          state_q, state_d;
    logic [BW-1:0]         boot_cnt_q, boot_cnt_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADX_LENGTH-1:0] instr_pc_q, instr_pc_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic                  pc_load, pc_inc, pc_hold;

    fetch_pc_reg #(.ADX_LENGTH(ADX_LENGTH)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (branch_target),
        .inc_i      (pc_inc),
        .hold_i     (pc_hold),
        .pc_o       (pc)
    );

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_hold    = 1'b1;

        unique case (state_q)
            BOOT: begin
                valid_d    = 1'b0;
                boot_cnt_d = boot_cnt_q + BW'(1);
                if (boot_cnt_q == BW'(BOOT_CYCLES - 1))
                    state_d = RUN;
            end
            RUN: begin
                // Branch wins even over stall: the word read this cycle is squashed.
                if (branch_en) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                end else if (stall) begin
                    pc_hold = 1'b1;
                end else if (im.im_data == HALT_WORD) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    instr_d    = im.im_data;
                    instr_pc_d = pc;
                    valid_d    = 1'b1;
                    pc_hold    = 1'b0;
                    pc_inc     = 1'b1;
                end
            end
            HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign im.im_adx   = pc;
    assign im.im_wren  = 1'b1;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues the expected IF/ID
// contents per valid cycle, a negedge monitor pops and compares.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_en;
    logic [6:0]  branch_target;
    logic [6:0]  pc, instr_pc;
    logic [31:0] instr;
    logic        instr_valid, halted;

    logic [31:0] mem [0:127];
    logic [38:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit_if #(.DATA_WIDTH(32), .ADX_LENGTH(7)) imem ();

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .im            (imem),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc            (pc),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    assign imem.im_data = mem[imem.im_adx];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock edge; optionally queue the IF/ID contents expected after it.
    task automatic tick(input logic exp_v, input logic [31:0] ei, input logic [6:0] ep);
        @(posedge clk);
        if (exp_v) exp_q.push_back({ei, ep});
        #1;
    endtask

    always @(negedge clk) begin
        chk("im_wren", {31'b0, imem.im_wren}, 32'd1);
        chk("im_adx", {25'b0, imem.im_adx}, {25'b0, pc});
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%0h/%0d required=none", instr, instr_pc);
            end else begin
                logic [38:0] e;
                e = exp_q.pop_front();
                chk("instr", instr, e[38:7]);
                chk("instr_pc", {25'b0, instr_pc}, {25'b0, e[6:0]});
            end
        end
    end

    task automatic boot_wait();
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 32'h0, 7'd0);
            chk("boot_pc", {25'b0, pc}, 32'd0);
            chk("boot_valid", {31'b0, instr_valid}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        for (int i = 0; i < 10; i++) mem[i] = 32'h100 + i;
        mem[10] = 32'hFFFF_FFFF;
        rst = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 7'd0;

        // Reset and boot
        tick(1'b0, 0, 0);
        tick(1'b0, 0, 0);
        chk("rst_pc", {25'b0, pc}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", {25'b0, instr_pc}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        rst = 1'b1;
        boot_wait();
        tick(1'b1, 32'h100, 7'd0);
        chk("pc_after_first", {25'b0, pc}, 32'd1);

        // Streaming up to the halt word
        for (int i = 1; i < 10; i++) tick(1'b1, 32'h100 + i, 7'(i));
        tick(1'b0, 0, 0);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_valid", {31'b0, instr_valid}, 32'd0);
        chk("halt_pc", {25'b0, pc}, 32'd10);
        branch_en = 1'b1; branch_target = 7'd2; stall = 1'b1;
        tick(1'b0, 0, 0);
        tick(1'b0, 0, 0);
        branch_en = 1'b0; stall = 1'b0;
        chk("halt_absorb_pc", {25'b0, pc}, 32'd10);
        chk("halt_absorb_flag", {31'b0, halted}, 32'd1);

        // Reset out of HALT
        rst = 1'b0;
        tick(1'b0, 0, 0);
        chk("rst_halt_flag", {31'b0, halted}, 32'd0);
        chk("rst_halt_pc", {25'b0, pc}, 32'd0);
        rst = 1'b1;
        boot_wait();
        tick(1'b1, 32'h100, 7'd0);

        // Stall at pc=4
        for (int i = 1; i < 4; i++) tick(1'b1, 32'h100 + i, 7'(i));
        chk("pre_stall_pc", {25'b0, pc}, 32'd4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'h103, 7'd3);
            chk("stall_pc", {25'b0, pc}, 32'd4);
        end
        stall = 1'b0;
        tick(1'b1, 32'h104, 7'd4);

        // Branch to 3, then branch-with-stall to 7
        branch_en = 1'b1; branch_target = 7'd3;
        tick(1'b0, 0, 0);
        chk("br_pc", {25'b0, pc}, 32'd3);
        chk("br_instr_hold", instr, 32'h104);
        branch_target = 7'd7; stall = 1'b1;
        tick(1'b0, 0, 0);
        chk("br_stall_pc", {25'b0, pc}, 32'd7);
        chk("br_stall_valid", {31'b0, instr_valid}, 32'd0);
        branch_en = 1'b0; stall = 1'b0;
        tick(1'b1, 32'h107, 7'd7);

        // Wrap 127 -> 0
        mem[127] = 32'hA; mem[0] = 32'hB;
        branch_en = 1'b1; branch_target = 7'd127;
        tick(1'b0, 0, 0);
        branch_en = 1'b0;
        tick(1'b1, 32'hA, 7'd127);
        tick(1'b1, 32'hB, 7'd0);
        chk("wrap_pc", {25'b0, pc}, 32'd1);
        tick(1'b1, 32'h101, 7'd1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
